calendar_bus_reader: RTL and testbench
======================================

Name: calendar_bus_reader

Overview:
- Read-side master for the shared calendar databus.
- Each time-keeping counter (month, day, hour, minute, …) drives its binary value onto the databus only while its enable input is high.
- This block sequences those enables one field at a time and samples the bus.
- It converts each sample to two BCD digits and presents registered digit pairs to the display/seven-segment stage.

Parameters:
- NUM_FIELDS, 3, number of counters scanned; field i drives enable[i] (1..8).
- DATA_W, 6, databus width in bits (4..7).
- SETTLE, 2, cycles enable is held before and including the sample cycle (>=1).
- CONTINUOUS, 0, 1 = restart a new frame automatically after frame_done.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clear_n  input  1  asynchronous active-low reset.
- start  input  1  request one scan frame; sampled only in IDLE.
- databus  input  DATA_W  shared bus; AND-gated counter value, 0 when no enable is high.
- enable  output  NUM_FIELDS  one-hot bus-drive enables; all-zero outside DRIVE.
- bcd  output  8*NUM_FIELDS  field i at [8i+7:8i]; tens in [8i+7:8i+4], units in [8i+3:8i].
- field_valid  output  NUM_FIELDS  one-cycle pulse on bit i when field i digits update.
- frame_done  output  1  one-cycle pulse after the last field is written.
- busy  output  1  high from the first DRIVE cycle through the last WRITE cycle.
- ovf  output  1  sticky: a sampled value exceeded 99.

Behaviour:
- Reset: clear_n low asynchronously forces the following, regardless of state, including mid-frame:
  - state IDLE, field index 0;
  - enable=0, bcd=0, field_valid=0, frame_done=0, busy=0, ovf=0.
- Reset release: first active edge after clear_n rises is treated as IDLE.
- States: IDLE, DRIVE, CONVERT, WRITE.
- IDLE:
  - enable=0, busy=0.
  - If start=1 (or CONTINUOUS=1), go to DRIVE with field index 0 and settle counter 0.
  - ovf clears on that transition.
- DRIVE:
  - enable = one-hot(field index), busy=1.
  - Held for exactly SETTLE cycles.
  - On the edge ending the last DRIVE cycle, databus is captured into a DATA_W shift register (enable still high), then go to CONVERT.
  - Bus changes after the capture edge have no effect.
- CONVERT:
  - enable=0.
  - Shift-add-3 (double-dabble) binary-to-BCD, one input bit per cycle, MSB first.
  - Exactly DATA_W cycles, then go to WRITE.
  - Uses an 8-bit tens/units scratch; the hundreds digit is tracked only as an overflow flag.
- WRITE (one cycle):
  - bcd[8i+7:8i] gets the converted pair, and field_valid[i]=1 in the same cycle the new digits appear.
  - If the captured value > 99: digits forced to 9,9 and ovf set to 1.
  - If field index < NUM_FIELDS-1: increment it and return to DRIVE.
  - Otherwise: frame_done=1 in this cycle, then go to IDLE.
- Timing:
  - Per-field latency is SETTLE + DATA_W + 1 cycles.
  - Frame length is NUM_FIELDS*(SETTLE+DATA_W+1) busy cycles.
  - At least one IDLE cycle occurs between frames, even with start held high or CONTINUOUS=1.
- start while busy: ignored, not queued.
- bcd hold: digits of fields not yet rescanned keep their previous frame values; no partial-digit update is ever visible.
- Bus drive: enable is never multi-hot and never high outside DRIVE; the block never drives the databus.
- Zero value: a sampled 0 (e.g. an unpowered or disabled counter) produces digits 0,0, not an error.

Test Plan:
- Defaults; bus model returns month=12, day=31, min=59; pulse start:
  - enable sequence 001,001,000×7,010,010,000×7,100,100,000×7;
  - bcd = 0x59_31_12;
  - field_valid pulses at busy cycles 9, 18, 27; frame_done in cycle 27; busy low at cycle 28.
- Pull clear_n low during CONVERT of field 1:
  - enable, bcd, busy, ovf go to 0 without a clock edge;
  - after release plus start, a full frame completes normally.
- DATA_W=7; field 0 returns 100, then next frame returns 5:
  - first frame gives bcd[7:0]=0x99 and ovf=1;
  - second frame gives 0x05 and ovf=0 (cleared at start).
- Hold start high for 3 frames:
  - each frame 27 busy cycles separated by exactly one IDLE cycle;
  - start pulses during busy produce no extra frames.
- Bus model changes field 0 value from 7 to 11 one cycle after the capture edge → bcd[7:0]=0x07.
- CONTINUOUS=1 with start tied low: frames repeat indefinitely after reset; month counter stepping 12→1 appears as 0x12 then 0x01.

Source files
------------

// File: rtl/calendar_bus_reader.sv
// calendar_bus_reader: read-side master for the shared calendar databus.
// Scans each time-keeping counter in turn by raising its bus enable, samples
// the databus, converts the sample to two BCD digits with a serial
// shift-add-3 converter and publishes the registered digit pair.
module calendar_bus_reader #(
    parameter int NUM_FIELDS = 3,
    parameter int DATA_W     = 6,
    parameter int SETTLE     = 2,
    parameter int CONTINUOUS = 0
) (
    input  logic                    clk,
    input  logic                    clear_n,
    input  logic                    start,
    input  logic [DATA_W-1:0]       databus,
    output logic [NUM_FIELDS-1:0]   enable,
    output logic [8*NUM_FIELDS-1:0] bcd,
    output logic [NUM_FIELDS-1:0]   field_valid,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    ovf
);

    localparam int IDX_W   = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int CNT_MAX = (SETTLE > DATA_W) ? SETTLE : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_FIELDS - 1);
    localparam logic             AUTO_FRAME  = (CONTINUOUS != 0);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRIVE   = 2'd1;
    localparam logic [1:0] ST_CONVERT = 2'd2;
    localparam logic [1:0] ST_WRITE   = 2'd3;

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;

    // Converter datapath: captured sample, tens/units scratch and the
    // hundreds digit reduced to a single "has overflowed" flag.
    logic [DATA_W-1:0] shreg;
    logic [7:0]        scratch;
    logic              hund;

    logic [7:0]        adj;
    logic [7:0]        next_scratch;
    logic              carry;
    logic              conv_over;

    // Add 3 to every BCD digit that is 5 or more before the next shift.
    function automatic logic [7:0] add3(input logic [7:0] d);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = d[7:4];
        units = d[3:0];
        if (tens >= 4'd5)
            tens = tens + 4'd3;
        if (units >= 4'd5)
            units = units + 4'd3;
        return {tens, units};
    endfunction

    // Values of 100 or more cannot be shown in two digits: clamp to 99.
    function automatic logic [7:0] sat99(input logic over, input logic [7:0] d);
        return over ? 8'h99 : d;
    endfunction

    // One double-dabble step: adjust, then shift in the next sample bit MSB
    // first; a bit leaving the tens digit means a nonzero hundreds digit.
    always_comb begin
        adj          = add3(scratch);
        carry        = adj[7];
        next_scratch = {adj[6:0], shreg[DATA_W-1]};
        conv_over    = hund | carry;
    end

    // Scan sequencer and published digit/overflow registers.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            cnt   <= '0;
            bcd   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start || AUTO_FRAME) begin
                        state <= ST_DRIVE;
                        idx   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_CONVERT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_CONVERT: begin
                    if (cnt == CONV_LAST) begin
                        // The final step result is written directly so the
                        // new digits are visible during the WRITE cycle.
                        state <= ST_WRITE;
                        for (int i = 0; i < NUM_FIELDS; i++) begin
                            if (idx == IDX_W'(i))
                                bcd[8*i +: 8] <= sat99(conv_over, next_scratch);
                        end
                        if (conv_over)
                            ovf <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (idx == IDX_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        cnt   <= '0;
                        state <= ST_DRIVE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Converter datapath: capture on the last DRIVE edge, shift during CONVERT.
    always_ff @(posedge clk) begin
        if (state == ST_DRIVE && cnt == SETTLE_LAST) begin
            shreg   <= databus;
            scratch <= '0;
            hund    <= 1'b0;
        end else if (state == ST_CONVERT) begin
            shreg   <= shreg << 1;
            scratch <= next_scratch;
            hund    <= conv_over;
        end
    end

    // Status outputs decoded from the registered state, so reset clears them
    // immediately and enable can never be multi-hot.
    always_comb begin
        enable      = (state == ST_DRIVE) ? (NUM_FIELDS'(1) << idx) : '0;
        field_valid = (state == ST_WRITE) ? (NUM_FIELDS'(1) << idx) : '0;
        frame_done  = (state == ST_WRITE) && (idx == IDX_LAST);
        busy        = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_calendar_bus_reader.sv
// Testbench for calendar_bus_reader: a default-parameter instance driven by
// start, and a DATA_W=7 free-running instance for the overflow and
// continuous-scan cases. Both share one clock and AND-gated bus models.
module tb_calendar_bus_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: defaults (3 fields, 6-bit bus, SETTLE 2, start-driven)
    logic        a_clear_n;
    logic        a_start;
    logic [5:0]  a_db;
    logic [2:0]  a_en;
    logic [23:0] a_bcd;
    logic [2:0]  a_fv;
    logic        a_fd;
    logic        a_busy;
    logic        a_ovf;
    logic [5:0]  a_v0, a_v1, a_v2;

    // Instance B: 7-bit bus, continuous scanning
    logic        b_clear_n;
    logic        b_start;
    logic [6:0]  b_db;
    logic [2:0]  b_en;
    logic [23:0] b_bcd;
    logic [2:0]  b_fv;
    logic        b_fd;
    logic        b_busy;
    logic        b_ovf;
    logic [6:0]  b_v0, b_v1, b_v2;

    calendar_bus_reader dut_a (
        .clk(clk), .clear_n(a_clear_n), .start(a_start), .databus(a_db),
        .enable(a_en), .bcd(a_bcd), .field_valid(a_fv), .frame_done(a_fd),
        .busy(a_busy), .ovf(a_ovf)
    );

    calendar_bus_reader #(.NUM_FIELDS(3), .DATA_W(7), .SETTLE(2), .CONTINUOUS(1)) dut_b (
        .clk(clk), .clear_n(b_clear_n), .start(b_start), .databus(b_db),
        .enable(b_en), .bcd(b_bcd), .field_valid(b_fv), .frame_done(b_fd),
        .busy(b_busy), .ovf(b_ovf)
    );

    // Counters drive the bus only while enabled; otherwise the bus reads 0.
    always_comb begin
        a_db = ({6{a_en[0]}} & a_v0) | ({6{a_en[1]}} & a_v1) | ({6{a_en[2]}} & a_v2);
        b_db = ({7{b_en[0]}} & b_v0) | ({7{b_en[1]}} & b_v1) | ({7{b_en[2]}} & b_v2);
    end

    typedef struct {
        logic [5:0]  v0;
        logic [5:0]  v1;
        logic [5:0]  v2;
        logic [23:0] exp_bcd;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_a_fd(output int n, output logic ok);
        ok = 1'b0;
        n  = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            n++;
            if (a_fd) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_b_fd(output int n, output logic ok);
        ok = 1'b0;
        n  = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            n++;
            if (b_fd) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Pulse start for one cycle, wait for frame_done, return with A in IDLE.
    task automatic run_a_frame(input string name);
        int   n;
        logic ok;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_a_fd(n, ok);
        check({name, "_done"}, 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int         n;
        logic       ok;
        int         f, p;
        logic [2:0] en_e, fv_e;
        logic       fd_e, busy_e;
        int         mism;
        int         fdcount;
        logic       exp_busy;

        vecs[0] = '{v0: 6'd0,  v1: 6'd0,  v2: 6'd0,  exp_bcd: 24'h000000};
        vecs[1] = '{v0: 6'd63, v1: 6'd10, v2: 6'd9,  exp_bcd: 24'h091063};
        vecs[2] = '{v0: 6'd1,  v1: 6'd50, v2: 6'd45, exp_bcd: 24'h455001};
        vecs[3] = '{v0: 6'd19, v1: 6'd40, v2: 6'd7,  exp_bcd: 24'h074019};
        vecs[4] = '{v0: 6'd39, v1: 6'd55, v2: 6'd2,  exp_bcd: 24'h025539};

        a_clear_n = 1'b0;
        a_start   = 1'b0;
        a_v0 = 6'd12; a_v1 = 6'd31; a_v2 = 6'd59;
        b_clear_n = 1'b0;
        b_start   = 1'b0;
        b_v0 = 7'd100; b_v1 = 7'd5; b_v2 = 7'd9;

        repeat (2) @(negedge clk);
        check("reset_a_ctrl", 32'({a_en, a_fv, a_fd, a_busy, a_ovf}), 32'd0);
        check("reset_a_bcd", 32'(a_bcd), 32'd0);
        check("reset_b_ctrl", 32'({b_en, b_fv, b_fd, b_busy, b_ovf}), 32'd0);
        a_clear_n = 1'b1;
        @(negedge clk);
        check("idle_after_release", 32'(a_busy), 32'd0);

        // Cycle-by-cycle frame trace: 12, 31, 59
        a_start = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            a_start = 1'b0;
            f      = (c - 1) / 9;
            p      = (c - 1) % 9;
            en_e   = (c <= 27 && p < 2)  ? 3'(1 << f) : 3'b000;
            fv_e   = (c <= 27 && p == 8) ? 3'(1 << f) : 3'b000;
            fd_e   = (c == 27);
            busy_e = (c <= 27);
            check($sformatf("trace_c%0d", c), 32'({a_en, a_fv, a_fd, a_busy}),
                  32'({en_e, fv_e, fd_e, busy_e}));
        end
        check("trace_bcd", 32'(a_bcd), 32'h593112);
        check("trace_ovf", 32'(a_ovf), 32'd0);

        // Table of bus values and expected digit triples
        for (int i = 0; i < 5; i++) begin
            a_v0 = vecs[i].v0; a_v1 = vecs[i].v1; a_v2 = vecs[i].v2;
            run_a_frame($sformatf("vec%0d", i));
            check($sformatf("vec%0d_bcd", i), 32'(a_bcd), 32'(vecs[i].exp_bcd));
            check($sformatf("vec%0d_ovf", i), 32'(a_ovf), 32'd0);
        end

        // Bus change just after the capture edge is ignored
        a_v0 = 6'd7;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a_v0 = 6'd11;
        wait_a_fd(n, ok);
        check("late_change_done", 32'(ok), 32'd1);
        check("late_change_bcd0", 32'(a_bcd[7:0]), 32'h07);
        @(negedge clk);

        // Bus change before the capture edge (second DRIVE cycle) is taken
        a_v0 = 6'd7;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        @(negedge clk);
        a_v0 = 6'd11;
        wait_a_fd(n, ok);
        check("early_change_done", 32'(ok), 32'd1);
        check("early_change_bcd0", 32'(a_bcd[7:0]), 32'h11);
        @(negedge clk);

        // start held high: three frames of 27 busy cycles, one IDLE between
        a_v0 = 6'd12; a_v1 = 6'd31; a_v2 = 6'd59;
        mism    = 0;
        fdcount = 0;
        a_start = 1'b1;
        for (int c = 1; c <= 83; c++) begin
            @(negedge clk);
            exp_busy = ((c - 1) % 28) != 27;
            if (a_busy !== exp_busy) mism++;
            if (a_fd) fdcount++;
        end
        a_start = 1'b0;
        for (int c = 84; c <= 88; c++) begin
            @(negedge clk);
            if (a_busy !== 1'b0) mism++;
            if (a_fd) fdcount++;
        end
        check("held_busy_pattern", 32'(mism), 32'd0);
        check("held_frame_count", 32'(fdcount), 32'd3);

        // Asynchronous reset during CONVERT of field 1
        a_v0 = 6'd21; a_v1 = 6'd42; a_v2 = 6'd3;
        a_start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            a_start = 1'b0;
        end
        check("pre_reset_busy", 32'(a_busy), 32'd1);
        check("pre_reset_bcd0", 32'(a_bcd[7:0]), 32'h21);
        a_clear_n = 1'b0;
        #1;
        check("async_reset_ctrl", 32'({a_en, a_fv, a_fd, a_busy, a_ovf}), 32'd0);
        check("async_reset_bcd", 32'(a_bcd), 32'd0);
        @(negedge clk);
        a_clear_n = 1'b1;
        @(negedge clk);
        run_a_frame("post_reset");
        check("post_reset_bcd", 32'(a_bcd), 32'h034221);

        // Continuous instance: overflow clamp, then ovf cleared on next frame
        b_clear_n = 1'b1;
        wait_b_fd(n, ok);
        check("b_frame1_done", 32'(ok), 32'd1);
        check("b_frame1_bcd", 32'(b_bcd), 32'h090599);
        check("b_frame1_ovf", 32'(b_ovf), 32'd1);
        check("b_frame1_fv", 32'(b_fv), 32'b100);
        b_v0 = 7'd5;
        wait_b_fd(n, ok);
        check("b_frame2_done", 32'(ok), 32'd1);
        check("b_frame2_bcd0", 32'(b_bcd[7:0]), 32'h05);
        check("b_frame2_ovf", 32'(b_ovf), 32'd0);
        check("b_frame_period", 32'(n), 32'd31);

        // Month counter stepping 12 -> 1 across continuous frames
        b_v0 = 7'd12;
        wait_b_fd(n, ok);
        check("b_month12_done", 32'(ok), 32'd1);
        check("b_month12", 32'(b_bcd[7:0]), 32'h12);
        b_v0 = 7'd1;
        wait_b_fd(n, ok);
        check("b_month1_done", 32'(ok), 32'd1);
        check("b_month1", 32'(b_bcd[7:0]), 32'h01);
        check("b_month1_period", 32'(n), 32'd31);

        // Largest 7-bit value clamps as well
        b_v2 = 7'd127;
        wait_b_fd(n, ok);
        check("b_max_done", 32'(ok), 32'd1);
        check("b_max_bcd", 32'(b_bcd), 32'h990501);
        check("b_max_ovf", 32'(b_ovf), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
